// File: rtl/sram_file_param.sv
// Single-port parametrised register-file SRAM with a registered read path,
// out-of-range error strobe and a self-timed bulk-clear sequencer.
module sram_file_param #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 12,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Address,
    input  logic [WIDTH-1:0]  Din,
    input  logic              CLR,
    output logic [WIDTH-1:0]  Dout,
    output logic              Valid,
    output logic              Busy,
    output logic              Err
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  dout_p1;
    logic              vld_p1;
    logic              err_p1;
    logic              busy_p1;
    logic              in_range;

    // Unimplemented addresses are rejected outright, never folded onto real words.
    assign in_range = {1'b0, Address} < DEPTH_EXT;

    // Request stage -> registered outputs (one-cycle latency)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state   <= IDLE;
            ptr     <= '0;
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
            busy_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (CLR) begin
                        err_p1  <= EN;
                        state   <= CLEAR;
                        ptr     <= '0;
                        busy_p1 <= 1'b1;
                    end else if (EN) begin
                        if (RW) begin
                            if (in_range) mem[Address] <= Din;
                            else          err_p1 <= 1'b1;
                        end else begin
                            vld_p1  <= 1'b1;
                            dout_p1 <= in_range ? mem[Address] : '0;
                            err_p1  <= !in_range;
                        end
                    end
                end
                CLEAR: begin
                    // Accesses during a clear are refused; Dout keeps its value.
                    mem[ptr] <= '0;
                    err_p1   <= EN;
                    if (ptr == LAST_PTR) begin
                        state   <= IDLE;
                        ptr     <= '0;
                        busy_p1 <= 1'b0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    ptr     <= '0;
                    busy_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign Dout  = dout_p1;
    assign Valid = vld_p1;
    assign Busy  = busy_p1;
    assign Err   = err_p1;

endmodule

// File: tb/tb_sram_file_param.sv
// Directed self-checking bench for sram_file_param: default 12x4 instance plus
// a 16x8 instance for the wider configuration.
module tb_sram_file_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, rw = 1'b0, clr = 1'b0;
    logic [3:0] addr = '0, din = '0;
    logic [3:0] dout;
    logic       valid, busy, err;

    logic       b_en = 1'b0, b_rw = 1'b0, b_clr = 1'b0;
    logic [3:0] b_addr = '0;
    logic [7:0] b_din = '0;
    logic [7:0] b_dout;
    logic       b_valid, b_busy, b_err;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    logic [3:0] model [12];

    always #5 clk = ~clk;

    sram_file_param u_dut (
        .CLK(clk), .RST(rst), .EN(en), .RW(rw), .Address(addr), .Din(din),
        .CLR(clr), .Dout(dout), .Valid(valid), .Busy(busy), .Err(err)
    );

    sram_file_param #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u_dut16 (
        .CLK(clk), .RST(rst), .EN(b_en), .RW(b_rw), .Address(b_addr), .Din(b_din),
        .CLR(b_clr), .Dout(b_dout), .Valid(b_valid), .Busy(b_busy), .Err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs across a rising edge, then settle past it.
    task automatic cyc(input logic e, input logic r, input logic [3:0] a,
                       input logic [3:0] d, input logic c);
        en = e; rw = r; addr = a; din = d; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d, input logic v,
                           input logic b, input logic e);
        chk({tag, ".dout"},  32'(dout),  32'(d));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".err"},   32'(err),   32'(e));
    endtask

    initial begin
        for (int i = 0; i < 12; i++) model[i] = 4'h0;

        // Reset
        cyc(1'b1, 1'b1, 4'd2, 4'hF, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
            chk_out("rd_default", 4'h0, 1'b1, 1'b0, 1'b0);
        end

        // Writes then back-to-back reads
        cyc(1'b1, 1'b1, 4'd3, 4'hA, 1'b0);
        chk_out("wr3", 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 4'd11, 4'h5, 1'b0);
        model[3] = 4'hA; model[11] = 4'h5;
        cyc(1'b1, 1'b0, 4'd3, 4'h0, 1'b0);
        chk_out("rd3", 4'hA, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd11, 4'h0, 1'b0);
        chk_out("rd11", 4'h5, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("idle_hold", 4'h5, 1'b0, 1'b0, 1'b0);

        cyc(1'b1, 1'b1, 4'd5, 4'h9, 1'b0);
        model[5] = 4'h9;
        cyc(1'b1, 1'b0, 4'd5, 4'h0, 1'b0);
        chk_out("wr_then_rd5", 4'h9, 1'b1, 1'b0, 1'b0);

        // Out of range
        cyc(1'b1, 1'b1, 4'd12, 4'hF, 1'b0);
        chk_out("oor_wr12", 4'h9, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 4'd15, 4'h0, 1'b0);
        chk_out("oor_rd15", 4'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("oor_after", 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
            chk_out("rd_after_oor", model[i], 1'b1, 1'b0, 1'b0);
        end

        // Fill with 0x7, then clear with a colliding read
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 4'(i), 4'h7, 1'b0);
        cyc(1'b1, 1'b0, 4'd2, 4'h0, 1'b1);
        chk_out("clr_start", 4'h5, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 12; i++) begin
            if (i == 4)      cyc(1'b1, 1'b0, 4'd6, 4'h0, 1'b0);
            else if (i == 2) cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b1);
            else             cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
            if (i == 4)      chk_out("clr_midread", 4'h5, 1'b0, 1'b1, 1'b1);
            else             chk_out("clr_busy", 4'h5, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("clr_done", 4'h5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
            chk_out("rd_after_clr", 4'h0, 1'b1, 1'b0, 1'b0);
        end

        // Reset during a clear
        cyc(1'b1, 1'b1, 4'd0, 4'h1, 1'b0);
        for (int i = 8; i < 12; i++) cyc(1'b1, 1'b1, 4'(i), 4'hE, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("pre_clr_rd0", 4'h1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b1);
        for (int i = 2; i < 5; i++) cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("busy4", 4'h1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("rst_midclr", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);
        chk_out("rst_idle", 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 4'(i), 4'h0, 1'b0);
            chk_out("rd_after_rst", 4'h0, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 4'd0, 4'h0, 1'b0);

        // 16x8 configuration
        b_en = 1'b1; b_rw = 1'b1; b_addr = 4'd15; b_din = 8'hC3;
        @(posedge clk); #1;
        chk("w8_wr15.err", 32'(b_err), 32'd0);
        b_rw = 1'b0; b_din = 8'h00;
        @(posedge clk); #1;
        chk("w8_rd15.dout",  32'(b_dout),  32'hC3);
        chk("w8_rd15.valid", 32'(b_valid), 32'd1);
        chk("w8_rd15.err",   32'(b_err),   32'd0);
        b_en = 1'b0; b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        chk("w8_clr_start.busy", 32'(b_busy), 32'd1);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            chk("w8_clr_busy", 32'(b_busy), 32'd1);
        end
        @(posedge clk); #1;
        chk("w8_clr_done.busy", 32'(b_busy), 32'd0);
        b_en = 1'b1; b_rw = 1'b0; b_addr = 4'd15;
        @(posedge clk); #1;
        chk("w8_rd_after_clr.dout",  32'(b_dout),  32'h00);
        chk("w8_rd_after_clr.valid", 32'(b_valid), 32'd1);
        b_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
